// File: rtl/mode_sequencer_if.sv
// mode_sequencer_if: bundles the button, menu and mode-status signals of
// mode_sequencer so the controller and its consumers share one port.
//
//   btn_select, btn_back  synchronised raw centre/left buttons
//   menu_state            mode highlighted by the menu
//   mode_valid            per-mode enable mask (bit 0 ignored)
//   activity              any user input this cycle (idle-timeout build only)
//   machine_state         current mode, 0 = menu
//   mode_enter/exit/reject one-cycle event pulses
//   oled_blank, busy      display blanking window / transition in progress
//
// master: the side that drives the buttons and menu (board / bench).
// slave : the mode_sequencer itself.
interface mode_sequencer_if #(
  parameter int unsigned NUM_MODES = 11
);
  logic                 btn_select;
  logic                 btn_back;
  logic [3:0]           menu_state;
  logic [NUM_MODES-1:0] mode_valid;
  logic                 activity;
  logic [3:0]           machine_state;
  logic                 mode_enter;
  logic                 mode_exit;
  logic                 mode_reject;
  logic                 oled_blank;
  logic                 busy;

  modport master (
    output btn_select, btn_back, menu_state, mode_valid, activity,
    input  machine_state, mode_enter, mode_exit, mode_reject, oled_blank, busy
  );

  modport slave (
    input  btn_select, btn_back, menu_state, mode_valid, activity,
    output machine_state, mode_enter, mode_exit, mode_reject, oled_blank, busy
  );
endinterface

// File: rtl/mode_sequencer.sv
// mode_sequencer: application-mode controller. Debounces release of the
// select/back buttons, validates the requested mode, and sequences
// MENU -> ENTER_BLANK -> ACTIVE -> EXIT_BLANK -> MENU with an OLED blanking
// window around every mode change.
//
// Ports:
//   clock    system clock
//   reset_n  asynchronous active-low reset (deasserted synchronously inside)
//   bus      mode_sequencer_if.slave (buttons, menu, mask, status outputs)
//
// Optional build macro: MODE_TIMEOUT_EN -- when defined, ACTIVE is also left
// after IDLE_TIMEOUT cycles without activity or any button held.
module mode_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 6_250_000,
  parameter int unsigned BLANK_CYCLES    = 1_000_000,
  parameter int unsigned NUM_MODES       = 11,
  parameter int unsigned IDLE_TIMEOUT    = 500_000_000
) (
  input  logic            clock,
  input  logic            reset_n,
  mode_sequencer_if.slave bus
);

  // ---------------------------------------------------------------------
  // Reset: asserted asynchronously, released two clocks later in sync.
  // ---------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  // ---------------------------------------------------------------------
  // Button trackers: index 0 = select, 1 = back.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_HELD,
    BTN_RELEASING
  } btn_state_e;

  btn_state_e  btn_state_q [2];
  btn_state_e  btn_state_d [2];
  logic [31:0] btn_cnt_q   [2];
  logic [31:0] btn_cnt_d   [2];
  logic [1:0]  btn_raw;
  logic [1:0]  fire;

  assign btn_raw = {bus.btn_back, bus.btn_select};

  // fire is asserted on the edge at which the released count reaches
  // DEBOUNCE_CYCLES-1; the count then returns to 0, so the stored value
  // never exceeds that limit and release-to-fire is DEBOUNCE_CYCLES clocks.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      btn_state_d[i] = btn_state_q[i];
      btn_cnt_d[i]   = btn_cnt_q[i];
      fire[i]        = 1'b0;
      unique case (btn_state_q[i])
        BTN_IDLE: begin
          if (btn_raw[i]) btn_state_d[i] = BTN_HELD;
        end
        BTN_HELD: begin
          if (!btn_raw[i]) begin
            btn_cnt_d[i] = '0;
            if (DEBOUNCE_CYCLES <= 1) begin
              fire[i]        = 1'b1;
              btn_state_d[i] = BTN_IDLE;
            end else begin
              btn_state_d[i] = BTN_RELEASING;
            end
          end
        end
        BTN_RELEASING: begin
          if (btn_raw[i]) begin
            btn_state_d[i] = BTN_HELD;
            btn_cnt_d[i]   = '0;
          end else if (btn_cnt_q[i] + 32'd1 == 32'(DEBOUNCE_CYCLES - 1)) begin
            fire[i]        = 1'b1;
            btn_state_d[i] = BTN_IDLE;
            btn_cnt_d[i]   = '0;
          end else begin
            btn_cnt_d[i] = btn_cnt_q[i] + 32'd1;
          end
        end
        default: begin
          btn_state_d[i] = BTN_IDLE;
          btn_cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Requested-mode validity: non-zero, in range, and enabled in the mask.
  // ---------------------------------------------------------------------
  logic sel_ok;

  always_comb begin
    sel_ok = 1'b0;
    for (int unsigned m = 1; m < NUM_MODES; m++) begin
      if (bus.menu_state == 4'(m) && bus.mode_valid[m]) sel_ok = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Main FSM with registered outputs.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_MENU,
    ST_ENTER_BLANK,
    ST_ACTIVE,
    ST_EXIT_BLANK
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  machine_state_q, machine_state_d;
  logic        mode_enter_q, mode_enter_d;
  logic        mode_exit_q, mode_exit_d;
  logic        mode_reject_q, mode_reject_d;
  logic        oled_blank_q, oled_blank_d;
  logic        busy_q, busy_d;
  logic [31:0] blank_cnt_q, blank_cnt_d;
  logic        do_exit;
`ifdef MODE_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
`endif

  always_comb begin
    state_d         = state_q;
    machine_state_d = machine_state_q;
    mode_enter_d    = 1'b0;
    mode_exit_d     = 1'b0;
    mode_reject_d   = 1'b0;
    oled_blank_d    = oled_blank_q;
    busy_d          = busy_q;
    blank_cnt_d     = blank_cnt_q;
    do_exit         = 1'b0;
`ifdef MODE_TIMEOUT_EN
    idle_cnt_d      = idle_cnt_q;
`endif

    unique case (state_q)
      ST_MENU: begin
        if (fire[0]) begin
          if (sel_ok) begin
            machine_state_d = bus.menu_state;
            mode_enter_d    = 1'b1;
            oled_blank_d    = 1'b1;
            busy_d          = 1'b1;
            blank_cnt_d     = '0;
            state_d         = ST_ENTER_BLANK;
          end else begin
            mode_reject_d = 1'b1;
          end
        end
      end
      ST_ENTER_BLANK, ST_EXIT_BLANK: begin
        if (blank_cnt_q == 32'(BLANK_CYCLES - 1)) begin
          oled_blank_d = 1'b0;
          busy_d       = 1'b0;
          blank_cnt_d  = '0;
          state_d      = (state_q == ST_ENTER_BLANK) ? ST_ACTIVE : ST_MENU;
`ifdef MODE_TIMEOUT_EN
          idle_cnt_d   = '0;
`endif
        end else begin
          blank_cnt_d = blank_cnt_q + 32'd1;
        end
      end
      ST_ACTIVE: begin
        if (fire[1]) begin
          do_exit = 1'b1;
        end
`ifdef MODE_TIMEOUT_EN
        else if (bus.activity || bus.btn_select || bus.btn_back) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == 32'(IDLE_TIMEOUT - 1)) begin
          do_exit = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 32'd1;
        end
`endif
      end
      default: state_d = ST_MENU;
    endcase

    if (do_exit) begin
      machine_state_d = '0;
      mode_exit_d     = 1'b1;
      oled_blank_d    = 1'b1;
      busy_d          = 1'b1;
      blank_cnt_d     = '0;
      state_d         = ST_EXIT_BLANK;
    end
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int unsigned i = 0; i < 2; i++) begin
        btn_state_q[i] <= BTN_IDLE;
        btn_cnt_q[i]   <= '0;
      end
      state_q         <= ST_MENU;
      machine_state_q <= '0;
      mode_enter_q    <= 1'b0;
      mode_exit_q     <= 1'b0;
      mode_reject_q   <= 1'b0;
      oled_blank_q    <= 1'b0;
      busy_q          <= 1'b0;
      blank_cnt_q     <= '0;
`ifdef MODE_TIMEOUT_EN
      idle_cnt_q      <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        btn_state_q[i] <= btn_state_d[i];
        btn_cnt_q[i]   <= btn_cnt_d[i];
      end
      state_q         <= state_d;
      machine_state_q <= machine_state_d;
      mode_enter_q    <= mode_enter_d;
      mode_exit_q     <= mode_exit_d;
      mode_reject_q   <= mode_reject_d;
      oled_blank_q    <= oled_blank_d;
      busy_q          <= busy_d;
      blank_cnt_q     <= blank_cnt_d;
`ifdef MODE_TIMEOUT_EN
      idle_cnt_q      <= idle_cnt_d;
`endif
    end
  end

  assign bus.machine_state = machine_state_q;
  assign bus.mode_enter    = mode_enter_q;
  assign bus.mode_exit     = mode_exit_q;
  assign bus.mode_reject   = mode_reject_q;
  assign bus.oled_blank    = oled_blank_q;
  assign bus.busy          = busy_q;

  // Mask bit 0 has no meaning; activity only matters in the timeout build.
  logic unused_inputs;
  assign unused_inputs = ^{bus.activity, bus.mode_valid[0]};

endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed, table-driven bench for mode_sequencer with
// DEBOUNCE_CYCLES=4, BLANK_CYCLES=3, IDLE_TIMEOUT=20. Each table row drives
// the inputs for one clock and lists the outputs expected just after it.
module tb_mode_sequencer;

  localparam int unsigned NM = 11;
  localparam logic [NM-1:0] ALL   = 11'h7FF;
  localparam logic [NM-1:0] V3OFF = 11'h7F7;

  logic clock;
  logic reset_n;

  mode_sequencer_if #(.NUM_MODES(NM)) bus ();

  mode_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .BLANK_CYCLES   (3),
    .NUM_MODES      (NM),
    .IDLE_TIMEOUT   (20)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          sel;
    logic          back;
    logic [3:0]    menu;
    logic [NM-1:0] valid;
    logic [3:0]    ms;
    logic          en;
    logic          ex;
    logic          rj;
    logic          bl;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, bus.machine_state, bus.mode_enter, bus.mode_exit,
            bus.mode_reject, bus.oled_blank, bus.busy};
  endfunction

  function automatic logic [31:0] pack_exp(input logic [3:0] ms, input logic en,
                                           input logic ex, input logic rj, input logic bl);
    return {23'd0, ms, en, ex, rj, bl, bl};
  endfunction

  task automatic row(input logic s, input logic b, input logic [3:0] m,
                     input logic [NM-1:0] v, input logic [3:0] ms,
                     input logic en, input logic ex, input logic rj, input logic bl);
    vecs.push_back('{sel: s, back: b, menu: m, valid: v, ms: ms,
                     en: en, ex: ex, rj: rj, bl: bl});
  endtask

  task automatic drive(input logic s, input logic b, input logic [3:0] m, input logic [NM-1:0] v);
    bus.btn_select = s;
    bus.btn_back   = b;
    bus.menu_state = m;
    bus.mode_valid = v;
  endtask

  // Press select for one clock then release; the enter pulse is due on
  // the fourth clock after release.
  task automatic press_select(input logic [3:0] m, input string name);
    drive(1'b1, 1'b0, m, ALL); tick();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b0, m, ALL); tick();
      check({name, "_pre"}, {31'd0, bus.mode_enter}, 32'd0);
    end
    drive(1'b0, 1'b0, m, ALL); tick();
    check({name, "_enter"}, outs(), pack_exp(m, 1'b1, 1'b0, 1'b0, 1'b1));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    drive(1'b0, 1'b0, 4'd0, ALL);
    bus.activity = 1'b0;

    // Legal entry, mode 4
    row(1,0,4,ALL, 0,0,0,0,0);
    row(1,0,4,ALL, 0,0,0,0,0);
    row(0,0,4,ALL, 0,0,0,0,0);
    row(0,0,4,ALL, 0,0,0,0,0);
    row(0,0,4,ALL, 0,0,0,0,0);
    row(0,0,4,ALL, 4,1,0,0,1);
    row(0,0,4,ALL, 4,0,0,0,1);
    row(0,0,4,ALL, 4,0,0,0,1);
    row(0,0,4,ALL, 4,0,0,0,0);
    row(0,0,4,ALL, 4,0,0,0,0);
    // Select in ACTIVE ignored, mask drop does not force exit
    row(1,0,7,'0,  4,0,0,0,0);
    row(0,0,7,'0,  4,0,0,0,0);
    row(0,0,7,'0,  4,0,0,0,0);
    row(0,0,7,'0,  4,0,0,0,0);
    row(0,0,7,'0,  4,0,0,0,0);
    row(0,0,7,'0,  4,0,0,0,0);
    // Back exit; select completing during EXIT_BLANK is dropped
    row(0,1,4,ALL, 4,0,0,0,0);
    row(1,0,4,ALL, 4,0,0,0,0);
    row(0,0,4,ALL, 4,0,0,0,0);
    row(0,0,4,ALL, 4,0,0,0,0);
    row(0,0,4,ALL, 0,0,1,0,1);
    row(0,0,4,ALL, 0,0,0,0,1);
    row(0,0,4,ALL, 0,0,0,0,1);
    row(0,0,4,ALL, 0,0,0,0,0);
    row(0,0,4,ALL, 0,0,0,0,0);
    // Reject: out of range
    row(1,0,12,ALL, 0,0,0,0,0);
    row(0,0,12,ALL, 0,0,0,0,0);
    row(0,0,12,ALL, 0,0,0,0,0);
    row(0,0,12,ALL, 0,0,0,0,0);
    row(0,0,12,ALL, 0,0,0,1,0);
    row(0,0,12,ALL, 0,0,0,0,0);
    // Reject: masked mode 3
    row(1,0,3,V3OFF, 0,0,0,0,0);
    row(0,0,3,V3OFF, 0,0,0,0,0);
    row(0,0,3,V3OFF, 0,0,0,0,0);
    row(0,0,3,V3OFF, 0,0,0,0,0);
    row(0,0,3,V3OFF, 0,0,0,1,0);
    row(0,0,3,V3OFF, 0,0,0,0,0);
    // Reject: menu itself
    row(1,0,0,ALL, 0,0,0,0,0);
    row(0,0,0,ALL, 0,0,0,0,0);
    row(0,0,0,ALL, 0,0,0,0,0);
    row(0,0,0,ALL, 0,0,0,0,0);
    row(0,0,0,ALL, 0,0,0,1,0);
    row(0,0,0,ALL, 0,0,0,0,0);
    // Back in MENU ignored
    row(0,1,4,ALL, 0,0,0,0,0);
    row(0,0,4,ALL, 0,0,0,0,0);
    row(0,0,4,ALL, 0,0,0,0,0);
    row(0,0,4,ALL, 0,0,0,0,0);
    row(0,0,4,ALL, 0,0,0,0,0);
    row(0,0,4,ALL, 0,0,0,0,0);
    // menu_state sampled only on the fire cycle
    row(1,0,3,V3OFF, 0,0,0,0,0);
    row(0,0,3,V3OFF, 0,0,0,0,0);
    row(0,0,3,V3OFF, 0,0,0,0,0);
    row(0,0,3,V3OFF, 0,0,0,0,0);
    row(0,0,6,V3OFF, 6,1,0,0,1);
    row(0,0,3,V3OFF, 6,0,0,0,1);
    row(0,0,3,V3OFF, 6,0,0,0,1);
    row(0,0,3,V3OFF, 6,0,0,0,0);
    row(0,1,3,V3OFF, 6,0,0,0,0);
    row(0,0,3,V3OFF, 6,0,0,0,0);
    row(0,0,3,V3OFF, 6,0,0,0,0);
    row(0,0,3,V3OFF, 6,0,0,0,0);
    row(0,0,3,V3OFF, 0,0,1,0,1);
    row(0,0,3,V3OFF, 0,0,0,0,1);
    row(0,0,3,V3OFF, 0,0,0,0,1);
    row(0,0,3,V3OFF, 0,0,0,0,0);

    // Reset state
    #2;
    check("reset_async", outs(), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    check("reset_released", outs(), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sel, vecs[i].back, vecs[i].menu, vecs[i].valid);
      tick();
      check($sformatf("row%0d", i), outs(),
            pack_exp(vecs[i].ms, vecs[i].en, vecs[i].ex, vecs[i].rj, vecs[i].bl));
    end

    // Bounce: low 2, high 1, then low 4 -> single fire on the 4th low
    drive(1'b1, 1'b0, 4'd5, ALL); tick();
    drive(1'b0, 1'b0, 4'd5, ALL); tick();
    check("bounce_low1", outs(), 32'd0);
    tick();
    check("bounce_low2", outs(), 32'd0);
    drive(1'b1, 1'b0, 4'd5, ALL); tick();
    check("bounce_high", outs(), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b0, 4'd5, ALL); tick();
      check($sformatf("bounce_wait%0d", k), outs(), 32'd0);
    end
    tick();
    check("bounce_enter", outs(), pack_exp(4'd5, 1'b1, 1'b0, 1'b0, 1'b1));
    tick();
    check("bounce_blank", outs(), pack_exp(4'd5, 1'b0, 1'b0, 1'b0, 1'b1));

    // Reset in the middle of ENTER_BLANK
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_blank", outs(), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    check("reset_mid_after", outs(), 32'd0);

    // FSM back in MENU: a fresh entry works
    press_select(4'd2, "post_reset");
    tick(); tick();
    check("post_reset_blank", {31'd0, bus.oled_blank}, 32'd1);
    tick();
    check("post_reset_active", outs(), pack_exp(4'd2, 1'b0, 1'b0, 1'b0, 1'b0));

    // Idle behaviour in ACTIVE
    for (int k = 1; k <= 19; k++) tick();
    check("idle_19", outs(), pack_exp(4'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
`ifdef MODE_TIMEOUT_EN
    check("idle_timeout_exit", outs(), pack_exp(4'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    for (int k = 0; k < 40; k++) tick();
    check("idle_back_in_menu", outs(), 32'd0);
`else
    check("idle_no_exit", outs(), pack_exp(4'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 60; k++) tick();
    check("idle_still_active", outs(), pack_exp(4'd2, 1'b0, 1'b0, 1'b0, 1'b0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Top-level application-mode controller: turns centre/left button presses into clean mode transitions and drives the `machine_state` bus that the OLED mux, menu and per-mode tasks consume.
- Replaces ad-hoc release counting with per-button debounced release detection, a transition FSM, validity gating of requested modes, and an OLED blanking window around every mode change.

Parameters:
- DEBOUNCE_CYCLES, 6_250_000: consecutive released cycles required before a press counts as complete.
- BLANK_CYCLES, 1_000_000: cycles `oled_blank` is held high on each enter/exit.
- NUM_MODES, 11: legal modes 0..NUM_MODES-1; mode 0 is the menu.
- IDLE_TIMEOUT, 500_000_000: inactivity limit in ACTIVE (only used with MODE_TIMEOUT_EN).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- btn_select  in  1  raw centre button, already synchronised
- btn_back  in  1  raw left button, already synchronised
- menu_state  in  4  mode currently highlighted by the menu
- mode_valid  in  NUM_MODES  per-mode enable mask; bit 0 ignored
- activity  in  1  any user input this cycle; timeout feature only
- machine_state  out  4  current mode; 0 = menu
- mode_enter  out  1  one-cycle pulse when a mode is entered
- mode_exit  out  1  one-cycle pulse when returning to the menu
- mode_reject  out  1  one-cycle pulse when a select is refused
- oled_blank  out  1  high while the display must show black
- busy  out  1  high in ENTER_BLANK and EXIT_BLANK

Behaviour:
- Reset (async assert, sync deassert internally):
  - All outputs 0; FSM in MENU; both button trackers IDLE; all counters 0.
- Button tracker, one instance per button. States IDLE, HELD, RELEASING.
  - IDLE -> HELD on button high.
  - HELD -> RELEASING on button low; counter cleared.
  - RELEASING: counter increments each low cycle. Button high returns to HELD and clears the counter.
  - When counter reaches DEBOUNCE_CYCLES-1, emit a one-cycle `fire` and go to IDLE. Latency from release to fire is exactly DEBOUNCE_CYCLES cycles.
  - Counter is 32 bit and cannot exceed DEBOUNCE_CYCLES-1.
- Main FSM. States MENU, ENTER_BLANK, ACTIVE, EXIT_BLANK.
  - MENU, select fire:
    - If menu_state != 0 and < NUM_MODES and mode_valid[menu_state]=1: latch menu_state into `machine_state`, pulse `mode_enter` in the same cycle, go to ENTER_BLANK.
    - Otherwise pulse `mode_reject` and stay in MENU.
    - Back fire in MENU is ignored.
  - ENTER_BLANK:
    - `oled_blank`=1 and `busy`=1 for exactly BLANK_CYCLES cycles, then go to ACTIVE.
    - All fires are dropped. Trackers keep running, so a press that completes here is lost, not queued.
  - ACTIVE:
    - Back fire: pulse `mode_exit`, set `machine_state`=0, go to EXIT_BLANK.
    - Select fire is ignored.
    - A change to `mode_valid[machine_state]` does not force an exit.
  - EXIT_BLANK: same blanking as ENTER_BLANK, then go to MENU.
- Simultaneous select and back fire: resolved by state; only the fire relevant to the current state acts.
- `machine_state` changes only on the `mode_enter` / `mode_exit` cycles. `menu_state` is sampled only on the select fire cycle.

Optional Feature:
- Macro: MODE_TIMEOUT_EN.
- Defined:
  - In ACTIVE, a 32-bit idle counter increments each cycle and clears on `activity`=1 or on any button high.
  - When the counter reaches IDLE_TIMEOUT-1, perform the same exit as a back fire: `mode_exit` pulse, `machine_state`=0, go to EXIT_BLANK.
  - The counter clears on entry to ACTIVE.
- Undefined:
  - `activity` is unused, no idle counter exists, and ACTIVE is left only by a back fire.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, BLANK_CYCLES=3, IDLE_TIMEOUT=20.
- Reset mid-ENTER_BLANK: assert reset_n=0 -> all outputs 0 within the same cycle; FSM in MENU after release.
- Legal entry: menu_state=4, mode_valid=all 1s, select high 2 cycles then low -> `mode_enter` exactly 4 cycles after release; `machine_state`=4; `oled_blank` high 3 cycles; then ACTIVE.
- Bounce: select released for 2 cycles, high 1 cycle, low 4 cycles -> a single fire, 4 cycles after the final release.
- Invalid select: menu_state=12, or menu_state=3 with mode_valid[3]=0, or menu_state=0 -> `mode_reject` pulse; `machine_state` stays 0; no blank.
- Back in ACTIVE, plus select during EXIT_BLANK: `mode_exit` pulse; `machine_state`=0; a select completing during EXIT_BLANK is dropped; MENU is reached with no entry.
- MODE_TIMEOUT_EN defined, ACTIVE with no activity for 20 cycles -> `mode_exit`; same bench without the macro -> stays in ACTIVE indefinitely.
